// File: rtl/osd_mam_wb_burst_if.sv
// osd_mam_wb_burst_if
//   Wishbone B3 bus-master back end for the MAM. Takes MAM access requests
//   and runs them as single beats or linear incrementing bursts (cti/bte).
//   Read data passes through a 2-entry buffer, so a slow consumer throttles
//   the bus with wait states instead of dropping words.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   req_valid/req_ready, req_rw,
//   req_addr, req_burst, req_beats     MAM request channel
//   write_valid/write_ready,
//   write_data, write_strb             MAM write data channel
//   read_valid/read_ready, read_data   MAM read data channel
//   cyc_o, stb_o, we_o, addr_o, dat_o,
//   sel_o, cti_o, bte_o                Wishbone master outputs
//   dat_i, ack_i, err_i                Wishbone slave responses
//   err_o                              registered pulse after an err_i beat
//   dbg_state_o                        current FSM state (IDLE/WRITE/READ/DRAIN)
//
// Handshakes: every valid/ready pair transfers exactly on a rising clock
// edge where both valid and ready are high; valid never waits for ready.

module osd_mam_wb_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_burst,
  input  logic [13:0]           req_beats,
  input  logic                  write_valid,
  output logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [SW-1:0]         write_strb,
  output logic                  read_valid,
  input  logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SW-1:0]         sel_o,
  output logic [2:0]            cti_o,
  output logic [1:0]            bte_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  burst_q, burst_d;
  logic [13:0]           rem_q, rem_d;
  logic                  err_q, err_d;

  // Read buffer: two entries, separate read/write pointers plus a fill count.
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wptr_q, rptr_q;
  logic [1:0]            cnt_q, cnt_d;

  logic                  last_beat;
  logic                  beat;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

  assign last_beat  = (rem_q == 14'd1);
  assign read_valid = (cnt_q != 2'd0);
  assign read_data  = mem_q[rptr_q];
  assign pop        = read_valid & read_ready;
  // ack_i and err_i together are one beat; the error wins and pushes zero.
  assign beat       = stb_o & (ack_i | err_i);
  assign push       = (state_q == READ) & beat;
  assign push_data  = err_i ? '0 : dat_i;

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign dat_o       = write_data;
  assign bte_o       = 2'b00;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    burst_d     = burst_q;
    rem_d       = rem_q;
    req_ready   = 1'b0;
    write_ready = 1'b0;
    cyc_o       = 1'b0;
    stb_o       = 1'b0;
    sel_o       = '0;
    cti_o       = 3'b000;

    case (state_q)
      IDLE: begin
        // Held low while reset is asserted so nothing is taken during reset.
        req_ready = ~rst_i;
        if (req_valid && !rst_i) begin
          addr_d  = req_addr;
          we_d    = req_rw;
          burst_d = req_burst;
          rem_d   = (req_burst && req_beats != 14'd0) ? req_beats : 14'd1;
          state_d = req_rw ? WRITE : READ;
        end
      end

      WRITE: begin
        cyc_o       = 1'b1;
        stb_o       = write_valid;
        sel_o       = burst_q ? {SW{1'b1}} : write_strb;
        write_ready = ack_i | err_i;
        if (beat) begin
          addr_d = addr_q + ADDR_WIDTH'(SW);
          if (rem_q != 14'd0) rem_d = rem_q - 14'd1;
          if (last_beat) state_d = IDLE;
        end
      end

      READ: begin
        cyc_o = 1'b1;
        // Only strobe when the buffer can take the returned word.
        stb_o = (cnt_q != 2'd2);
        sel_o = {SW{1'b1}};
        if (beat) begin
          addr_d = addr_q + ADDR_WIDTH'(SW);
          if (rem_q != 14'd0) rem_d = rem_q - 14'd1;
          if (last_beat) state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Leave as soon as the final word is being popped.
        if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (state_q == WRITE || state_q == READ) begin
      if (burst_q) cti_o = last_beat ? 3'b111 : 3'b010;
    end
  end

  assign err_d = beat & err_i;
  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      rem_q   <= 14'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/osd_mam_wb_burst_if.md
# osd_mam_wb_burst_if

Wishbone B3 bus-master back end for the memory access module (MAM), successor to the single-beat MAM Wishbone interface. It accepts MAM access requests and runs them on the system bus as real incrementing bursts (cti/bte), with parametrised data width. Read bursts go through a 2-entry read buffer, so a slow MAM consumer inserts wait states instead of losing data. It sits between the MAM packet engine and the system Wishbone interconnect.

## Interface
- DATA_WIDTH, 32: bus data width in bits; legal values 16, 32, 64.
- ADDR_WIDTH, 32: byte address width.
- SW, DATA_WIDTH/8: byte-select width (derived, not overridable).
- clk_i  in  1  single clock; everything is sampled on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid / req_ready  in/out  1  request handshake; a request transfers when both are high.
- req_rw  in  1  0 = read, 1 = write.
- req_addr  in  ADDR_WIDTH  base byte address, aligned to SW.
- req_burst  in  1  0 = single beat, 1 = incrementing burst.
- req_beats  in  14  burst length in words; 0 is treated as 1; ignored when req_burst=0.
- write_valid / write_ready  in/out  1  write data handshake.
- write_data  in  DATA_WIDTH  write word.
- write_strb  in  SW  byte strobe; used only for single-beat writes.
- read_valid / read_ready  out/in  1  read data handshake.
- read_data  out  DATA_WIDTH  read word (head of the read buffer).
- cyc_o, stb_o, we_o  out  1  Wishbone control.
- addr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- sel_o  out  SW  Wishbone byte select.
- cti_o  out  3  cycle type identifier.
- bte_o  out  2  burst type extension; always 2'b00 (linear).
- ack_i  in  1  Wishbone acknowledge (classic; may come in the same cycle as stb_o).
- err_i  in  1  Wishbone error; terminates a beat exactly like ack_i.
- err_o  out  1  one-cycle pulse, registered, on the cycle after any err_i beat.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready = 1.
  - On request transfer: latch addr_o <= req_addr, we_o <= req_rw, and remaining <= (req_burst ? max(req_beats,1) : 1).
  - Next state is WRITE or READ.
- cyc_o is high in WRITE and READ and low in IDLE and DRAIN. cyc_o stays high across stb_o wait states within a burst.
- cti_o:
  - Single beat: 3'b000.
  - Burst: 3'b010 while remaining > 1, and 3'b111 on the last beat (remaining == 1).
- WRITE:
  - stb_o = write_valid (combinational).
  - dat_o = write_data.
  - sel_o = write_strb for single beat, all-ones for a burst.
  - write_ready = ack_i | err_i.
  - On each termination: addr_o += SW, remaining -= 1. When remaining was 1, go to IDLE.
- READ:
  - stb_o = 1 while the buffer has a free entry.
  - sel_o = all-ones.
  - On termination: push dat_i into the buffer (push 0 on err_i), addr_o += SW, remaining -= 1. When remaining was 1, go to DRAIN.
- DRAIN: wait for the buffer to empty, then go to IDLE.
- Read buffer:
  - 2-entry FIFO.
  - read_valid = not empty; read_data = head.
  - Pop on read_valid & read_ready.
  - Push and pop in the same cycle are allowed when full.
  - Reads occupy READ and DRAIN only.
- addr_o wraps modulo 2^ADDR_WIDTH; no 1 KiB boundary checks.
- remaining is 14 bits and never underflows.
- dat_o and sel_o are don't-care when stb_o = 0 (drive them as defined anyway).

## Timing
- Reset (async assert, sync release):
  - state = IDLE.
  - cyc_o = stb_o = we_o = 0, addr_o = 0, cti_o = 0, err_o = 0.
  - Read buffer empty, read_valid = 0.
  - req_ready = 0 while rst_i is high, 1 from the first cycle after release.
- Reset mid-burst aborts immediately: cyc_o drops asynchronously and buffered read data is discarded.
- Request to first stb_o: 1 cycle.
- Back-to-back write beats: 1 per cycle when write_valid and ack_i are continuously high.
- Read throughput: 1 beat per cycle while read_ready is high.
  - read_ready low for 2 cycles fills the buffer; stb_o then drops and the address holds until a pop.
  - stb_o reasserts the cycle after the pop.
- A new request is accepted no earlier than the cycle after the last write ack, or after the last read word is popped.
- ack_i and err_i together count as one beat, with err precedence (push 0).

## Test plan
- Single write, DATA_WIDTH=32, addr 0x100, data 0xDEADBEEF, strb 4'b0011, ack_i same cycle:
  - Required: one stb_o cycle with cti=000, sel=0011, we=1.
  - Then IDLE, with req_ready high the next cycle.
- Read burst of 4 at 0x200, slave acks every cycle, read_ready low for cycles 1–3:
  - Required: 2 acks, then stb_o drops.
  - Required: addresses 0x200, 0x204, 0x208, 0x20C.
  - Required: cti 010, 010, 010, 111.
  - Required: all 4 words delivered in order.
- Write burst of 3 with write_valid low for 2 cycles before beat 2:
  - Required: cyc_o stays high, stb_o low during the gap, write_ready pulses exactly 3 times.
- req_burst=1 with req_beats=0:
  - Required: exactly one beat with cti=111.
- err_i on beat 2 of a 3-beat read:
  - Required: read_data sequence w0, 0, w2.
  - Required: err_o pulses once.
- rst_i asserted mid-read-burst:
  - Required: cyc_o/stb_o low in the same cycle and read_valid low.
  - Required: req_ready high the first cycle after release.
